// File: rtl/key_event_ctl.sv
// key_event_ctl: N-key synchroniser, debouncer and hold/long/repeat event generator.
// Event pulses are registered on the same edge that updates KEY_LEVEL.
module key_event_ctl #(
    parameter int N_KEYS       = 7,
    parameter int TICK_DIV     = 1000000,
    parameter int DEB_TICKS    = 3,
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              SYSCLK,
    input  logic              RST_B,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              REPEAT_EN,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_LONG,
    output logic [N_KEYS-1:0] KEY_REPEAT,
    output logic              TICK
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    localparam logic [PW-1:0] DIV_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    localparam logic [N_KEYS-1:0] REL_PIN = {N_KEYS{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    logic [PW-1:0]     div_q;
    logic [PW-1:0]     div_d;
    logic              tick;
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] raw;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;
    assign TICK  = tick;

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Synchronisers idle at the released pin level so reset never fakes a press.
    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            sync1_q <= REL_PIN;
            sync2_q <= REL_PIN;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign raw = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic          lvl_q;
        logic          prs_q;
        logic          rel_q;
        logic          lng_q;
        logic          rep_q;
        logic [DW-1:0] deb_q;
        logic [HW-1:0] hold_q;
        logic [RW-1:0] rcnt_q;
        state_t        st_q;
        logic          flip;

        // Debounced level is about to toggle on this edge.
        assign flip = tick && (raw[k] != lvl_q) && (deb_q == DEB_LAST);

        always_ff @(posedge SYSCLK or negedge RST_B) begin
            if (!RST_B) begin
                lvl_q  <= 1'b0;
                prs_q  <= 1'b0;
                rel_q  <= 1'b0;
                lng_q  <= 1'b0;
                rep_q  <= 1'b0;
                deb_q  <= '0;
                hold_q <= '0;
                rcnt_q <= '0;
                st_q   <= IDLE;
            end else begin
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                lng_q <= 1'b0;
                rep_q <= 1'b0;
                if (tick) begin
                    if (raw[k] != lvl_q) begin
                        if (deb_q == DEB_LAST) begin
                            lvl_q <= ~lvl_q;
                            deb_q <= '0;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end else begin
                        deb_q <= '0;
                    end
                end
                unique case (st_q)
                    IDLE: begin
                        if (flip) begin
                            prs_q  <= 1'b1;
                            hold_q <= '0;
                            st_q   <= HELD;
                        end
                    end
                    HELD: begin
                        if (flip) begin
                            rel_q <= 1'b1;
                            st_q  <= IDLE;
                        end else if (tick) begin
                            if (hold_q == LONG_LAST) begin
                                lng_q  <= 1'b1;
                                rcnt_q <= '0;
                                st_q   <= LONG;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                    end
                    LONG: begin
                        if (flip) begin
                            rel_q <= 1'b1;
                            st_q  <= IDLE;
                        end else if (tick) begin
                            if (rcnt_q == REP_LAST) begin
                                rcnt_q <= '0;
                                rep_q  <= REPEAT_EN;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end

        assign KEY_LEVEL[k]   = lvl_q;
        assign KEY_PRESS[k]   = prs_q;
        assign KEY_RELEASE[k] = rel_q;
        assign KEY_LONG[k]    = lng_q;
        assign KEY_REPEAT[k]  = rep_q;
    end

endmodule

// File: tb/tb_key_event_ctl.sv
// tb_key_event_ctl: directed scenarios for key_event_ctl against a tick-history
// model, plus literal timing expectations for press, long, repeat and reset.
module tb_key_event_ctl;

    localparam int NK = 7;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int LT = 5;
    localparam int RT = 2;

    logic          SYSCLK = 1'b0;
    logic          RST_B = 1'b0;
    logic          REPEAT_EN = 1'b0;
    logic [NK-1:0] KEY = '1;
    logic [NK-1:0] KEY_LEVEL;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;
    logic [NK-1:0] KEY_LONG;
    logic [NK-1:0] KEY_REPEAT;
    logic          TICK;

    int errors = 0;
    int checks = 0;
    int gcyc = 0;

    always #5 SYSCLK = ~SYSCLK;

    key_event_ctl #(
        .N_KEYS      (NK),
        .TICK_DIV    (TD),
        .DEB_TICKS   (DT),
        .LONG_TICKS  (LT),
        .REPEAT_TICKS(RT),
        .ACTIVE_LOW  (1)
    ) dut (
        .SYSCLK     (SYSCLK),
        .RST_B      (RST_B),
        .KEY        (KEY),
        .REPEAT_EN  (REPEAT_EN),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_LONG   (KEY_LONG),
        .KEY_REPEAT (KEY_REPEAT),
        .TICK       (TICK)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [NK-1:0] act,
                        input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, gcyc);
        end
    endtask

    // Model: level flips once the last DT tick samples all disagree with it;
    // hold events follow from the number of ticks elapsed since the press.
    int            m_cyc;
    logic [NK-1:0] m_s1, m_s2;
    logic [NK-1:0] m_lvl, m_prs, m_rel, m_lng, m_rep;
    logic [DT-1:0] m_hist [NK];
    int            m_held [NK];

    always @(posedge SYSCLK or negedge RST_B) begin : model
        logic [NK-1:0] raw;
        logic          tk;
        if (!RST_B) begin
            m_cyc = 0;
            m_s1 = '1;
            m_s2 = '1;
            m_lvl = '0;
            m_prs = '0;
            m_rel = '0;
            m_lng = '0;
            m_rep = '0;
            for (int k = 0; k < NK; k++) begin
                m_hist[k] = '0;
                m_held[k] = 0;
            end
        end else begin
            raw = ~m_s2;
            tk = (m_cyc % TD) == TD - 1;
            m_s2 = m_s1;
            m_s1 = KEY;
            m_prs = '0;
            m_rel = '0;
            m_lng = '0;
            m_rep = '0;
            if (tk) begin
                for (int k = 0; k < NK; k++) begin
                    m_hist[k] = {m_hist[k][DT-2:0], raw[k]};
                    if (m_hist[k] == {DT{~m_lvl[k]}}) begin
                        m_lvl[k] = ~m_lvl[k];
                        if (m_lvl[k]) begin
                            m_prs[k] = 1'b1;
                            m_held[k] = 0;
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end else if (m_lvl[k]) begin
                        m_held[k]++;
                        if (m_held[k] == LT)
                            m_lng[k] = 1'b1;
                        else if (m_held[k] > LT && (m_held[k] - LT) % RT == 0)
                            m_rep[k] = REPEAT_EN;
                    end
                end
            end
            m_cyc++;
        end
    end

    int p_cnt [NK], p_cyc [NK], l_cnt [NK], l_cyc [NK];
    int r_cnt [NK], r_cyc [NK], rel_cnt [NK], gap_bad [NK];

    task automatic clear_stats();
        for (int k = 0; k < NK; k++) begin
            p_cnt[k] = 0; p_cyc[k] = 0; l_cnt[k] = 0; l_cyc[k] = 0;
            r_cnt[k] = 0; r_cyc[k] = 0; rel_cnt[k] = 0; gap_bad[k] = 0;
        end
    endtask

    // Per-cycle comparison against the model, plus event bookkeeping.
    always @(negedge SYSCLK) begin : cmp
        logic [NK-1:0] exp_tick;
        gcyc++;
        exp_tick = '0;
        exp_tick[0] = RST_B && ((m_cyc % TD) == TD - 1);
        chkv("level", KEY_LEVEL, m_lvl);
        chkv("press", KEY_PRESS, m_prs);
        chkv("release", KEY_RELEASE, m_rel);
        chkv("long", KEY_LONG, m_lng);
        chkv("repeat", KEY_REPEAT, m_rep);
        chkv("tick", {{(NK-1){1'b0}}, TICK}, exp_tick);
        for (int k = 0; k < NK; k++) begin
            if (KEY_PRESS[k] === 1'b1) begin
                p_cnt[k]++;
                p_cyc[k] = gcyc;
            end
            if (KEY_LONG[k] === 1'b1) begin
                l_cnt[k]++;
                l_cyc[k] = gcyc;
            end
            if (KEY_REPEAT[k] === 1'b1) begin
                if (gcyc - (r_cnt[k] == 0 ? l_cyc[k] : r_cyc[k]) != TD * RT)
                    gap_bad[k]++;
                r_cnt[k]++;
                r_cyc[k] = gcyc;
            end
            if (KEY_RELEASE[k] === 1'b1) rel_cnt[k]++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge SYSCLK);
        #1;
    endtask

    task automatic hold_test(input logic ren, input int exp_reps, input string tag);
        int start;
        clear_stats();
        REPEAT_EN = ren;
        start = gcyc;
        KEY[1] = 1'b0;
        step(100);
        KEY[1] = 1'b1;
        step(30);
        chk({tag, "_press_cnt"}, p_cnt[1], 1);
        chk({tag, "_long_cnt"}, l_cnt[1], 1);
        chk({tag, "_long_delay"}, l_cyc[1] - p_cyc[1], 20);
        chk({tag, "_rep_cnt"}, r_cnt[1], exp_reps);
        chk({tag, "_rep_gap_bad"}, gap_bad[1], 0);
        chk({tag, "_rel_cnt"}, rel_cnt[1], 1);
        chk({tag, "_press_lat_ok"}, int'(p_cyc[1] - start inside {[11:15]}), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int start;
        int others;
        int n;
        clear_stats();
        step(3);
        chkv("rst_level", KEY_LEVEL, '0);
        chkv("rst_press", KEY_PRESS | KEY_RELEASE | KEY_LONG | KEY_REPEAT, '0);
        chk("rst_tick", int'(TICK), 0);
        #1 RST_B = 1'b1;
        step(2);

        // 1: single press latency and isolation.
        clear_stats();
        start = gcyc;
        KEY[0] = 1'b0;
        step(40);
        chk("s1_press_cnt", p_cnt[0], 1);
        chk("s1_press_lat_ok", int'(p_cyc[0] - start inside {[11:15]}), 1);
        chkv("s1_level", KEY_LEVEL, 7'b0000001);
        others = 0;
        for (int k = 1; k < NK; k++) others += p_cnt[k];
        chk("s1_other_press", others, 0);
        KEY[0] = 1'b1;
        step(30);
        chk("s1_rel_cnt", rel_cnt[0], 1);
        chkv("s1_level_off", KEY_LEVEL, '0);

        // 2: short glitch is rejected.
        clear_stats();
        KEY[2] = 1'b0;
        step(6);
        KEY[2] = 1'b1;
        step(30);
        others = 0;
        for (int k = 0; k < NK; k++) others += p_cnt[k];
        chk("s2_no_press", others, 0);
        chkv("s2_level", KEY_LEVEL, '0);

        // 3 and 4: long press with and without auto-repeat.
        hold_test(1'b1, 9, "s3");
        hold_test(1'b0, 0, "s4");

        // 5: simultaneous presses.
        clear_stats();
        KEY[3] = 1'b0;
        KEY[4] = 1'b0;
        step(30);
        chk("s5_press3", p_cnt[3], 1);
        chk("s5_press4", p_cnt[4], 1);
        chk("s5_same_cycle", p_cyc[3] - p_cyc[4], 0);
        chkv("s5_level", KEY_LEVEL, 7'b0011000);
        KEY[3] = 1'b1;
        KEY[4] = 1'b1;
        step(30);

        // 6: reset while in LONG.
        clear_stats();
        REPEAT_EN = 1'b1;
        KEY[5] = 1'b0;
        n = 0;
        while (l_cnt[5] == 0 && n < 60) begin
            step(1);
            n++;
        end
        chk("s6_long_reached", l_cnt[5], 1);
        step(3);
        #1 RST_B = 1'b0;
        #1;
        chkv("s6_rst_level", KEY_LEVEL, '0);
        chkv("s6_rst_pulses", KEY_PRESS | KEY_RELEASE | KEY_LONG | KEY_REPEAT, '0);
        chk("s6_rst_tick", int'(TICK), 0);
        step(3);
        clear_stats();
        #1 RST_B = 1'b1;
        start = gcyc;
        step(20);
        chk("s6_press_cnt", p_cnt[5], 1);
        chk("s6_press_lat_ok", int'(p_cyc[5] - start inside {[11:15]}), 1);
        chk("s6_no_release", rel_cnt[5], 0);
        KEY[5] = 1'b1;
        step(30);
        chkv("s6_level_off", KEY_LEVEL, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
